// File: rtl/led_game_autoplayer.sv
// Automatic player for the LED reaction game: answers each LED
// rising edge with a timed button press, one request queued ahead.
module led_game_autoplayer #(
  parameter int REACT_CYCLES = 4,
  parameter int HOLD_CYCLES  = 6,
  parameter int GAP_CYCLES   = 6,
  parameter int CNT_W        = 8
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             LedVerde,
  input  logic             LedRED,
  input  logic             LedFin,
  output logic             BotonA,
  output logic             BotonB,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] PressCount,
  output logic [CNT_W-1:0] MissCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PRESS,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [15:0] REACT_LD = 16'(REACT_CYCLES - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LD   = 16'(GAP_CYCLES - 1);

  state_e      state_q;
  logic [15:0] timer_q;
  logic        verde_q;
  logic        red_q;
  logic        sel_q;
  logic        pend_v_q;
  logic        pend_t_q;

  logic        ev_v;
  logic        ev_r;
  logic        active;
  logic        slot_v;
  logic        slot_t;
  logic [1:0]  miss_n;
  logic        tmr_zero;

  assign ev_v     = LedVerde & ~verde_q;
  assign ev_r     = LedRED & ~red_q;
  assign tmr_zero = (timer_q == 16'd0);
  assign active   = (state_q == S_WAIT) ||
                    (state_q == S_PRESS) ||
                    (state_q == S_GAP);

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [1:0]       b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Slot contents after this cycle's events; sel/pending type 1 = BotonB.
  always_comb begin
    slot_v = pend_v_q;
    slot_t = pend_t_q;
    miss_n = 2'd0;
    if (active) begin
      if (ev_v) begin
        if (slot_v) begin
          miss_n = miss_n + 2'd1;
        end else begin
          slot_v = 1'b1;
          slot_t = 1'b0;
        end
      end
      if (ev_r) begin
        if (slot_v) begin
          miss_n = miss_n + 2'd1;
        end else begin
          slot_v = 1'b1;
          slot_t = 1'b1;
        end
      end
    end else if (state_q == S_IDLE && ev_v && ev_r) begin
      miss_n = 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      timer_q    <= 16'd0;
      verde_q    <= 1'b0;
      red_q      <= 1'b0;
      sel_q      <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_t_q   <= 1'b0;
      BotonA     <= 1'b0;
      BotonB     <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      PressCount <= '0;
      MissCount  <= '0;
    end else begin
      verde_q <= LedVerde;
      red_q   <= LedRED;
      if (!Enable) begin
        state_q  <= S_IDLE;
        pend_v_q <= 1'b0;
        BotonA   <= 1'b0;
        BotonB   <= 1'b0;
        Busy     <= 1'b0;
        Done     <= 1'b0;
      end else if (LedFin) begin
        state_q  <= S_DONE;
        pend_v_q <= 1'b0;
        BotonA   <= 1'b0;
        BotonB   <= 1'b0;
        Busy     <= 1'b0;
        Done     <= 1'b1;
      end else begin
        MissCount <= sat_add(MissCount, miss_n);
        if (active) begin
          pend_v_q <= slot_v;
          pend_t_q <= slot_t;
          timer_q  <= timer_q - 16'd1;
        end
        unique case (state_q)
          S_IDLE: begin
            if (ev_v || ev_r) begin
              state_q <= S_WAIT;
              timer_q <= REACT_LD;
              sel_q   <= ~ev_v;
              Busy    <= 1'b1;
            end
          end
          S_WAIT: begin
            if (tmr_zero) begin
              state_q <= S_PRESS;
              timer_q <= HOLD_LD;
              BotonA  <= ~sel_q;
              BotonB  <= sel_q;
            end
          end
          S_PRESS: begin
            if (tmr_zero) begin
              state_q    <= S_GAP;
              timer_q    <= GAP_LD;
              BotonA     <= 1'b0;
              BotonB     <= 1'b0;
              PressCount <= sat_add(PressCount, 2'd1);
            end
          end
          S_GAP: begin
            if (tmr_zero) begin
              if (slot_v) begin
                state_q  <= S_WAIT;
                timer_q  <= REACT_LD;
                sel_q    <= slot_t;
                pend_v_q <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                Busy    <= 1'b0;
              end
            end
          end
          S_DONE: begin
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
